// File: rtl/fetch_controller_if.sv
// Fetch controller bus bundle: instruction-memory request/response plus the
// decode handshake and redirect inputs. The controller uses the master modport,
// and the memory/decode environment uses the slave modport.
interface fetch_controller_if;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  logic [31:0] instr;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] pc_out;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        halted;

  modport master (
    output mem_req,
    output mem_addr,
    input  mem_rdata,
    input  mem_ack,
    output instr,
    output instr_valid,
    input  instr_ready,
    output pc_out,
    input  redirect,
    input  redirect_pc,
    output halted
  );

  modport slave (
    input  mem_req,
    input  mem_addr,
    output mem_rdata,
    output mem_ack,
    input  instr,
    input  instr_valid,
    output instr_ready,
    input  pc_out,
    output redirect,
    output redirect_pc,
    input  halted
  );
endinterface

// File: rtl/fetch_controller.sv
// Instruction fetch controller.
// The controller requests one word at the current pc and waits for the memory
// ack. It then holds the fetched word for decode until decode accepts it, and
// after that it advances pc by 4. A redirect overrides everything. It reloads pc
// with the word-aligned target and drops any in-flight response or held word.
// Optional feature: define FETCH_ZERO_HALT_EN so that accepting an all-zero
// instruction word parks the controller in HALT until a redirect arrives.
module fetch_controller #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input logic                clk,
  input logic                rst,
  fetch_controller_if.master bus
);

  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StHold,
    StHalt
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc_out_q, pc_out_d;
  logic [31:0] pc_inc;

  // pc + 4 wraps naturally modulo 2^32.
  assign pc_inc = pc_q + 32'd4;

  // Next-state and datapath update. Redirect is applied last so that it wins.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    instr_d  = instr_q;
    pc_out_d = pc_out_q;

    unique case (state_q)
      StIdle: begin
        state_d = StReq;
      end
      StReq: begin
        if (bus.mem_ack) begin
          instr_d  = bus.mem_rdata;
          pc_out_d = pc_q;
          state_d  = StHold;
        end
      end
      StHold: begin
        if (bus.instr_ready) begin
`ifdef FETCH_ZERO_HALT_EN
          if (instr_q == 32'h0000_0000) begin
            state_d = StHalt;
          end else begin
            pc_d    = pc_inc;
            state_d = StReq;
          end
`else
          pc_d    = pc_inc;
          state_d = StReq;
`endif
        end
      end
      StHalt: begin
        state_d = StHalt;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // A response or handshake in the same cycle as a redirect is discarded.
    if (bus.redirect) begin
      pc_d     = {bus.redirect_pc[31:2], 2'b00};
      instr_d  = instr_q;
      pc_out_d = pc_out_q;
      state_d  = StReq;
    end
  end

  // State and datapath registers with an asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      pc_q     <= RESET_PC;
      instr_q  <= 32'h0000_0000;
      pc_out_q <= RESET_PC;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      instr_q  <= instr_d;
      pc_out_q <= pc_out_d;
    end
  end

  assign bus.mem_req     = (state_q == StReq);
  assign bus.mem_addr    = pc_q;
  assign bus.instr       = instr_q;
  assign bus.instr_valid = (state_q == StHold);
  assign bus.pc_out      = pc_out_q;
`ifdef FETCH_ZERO_HALT_EN
  assign bus.halted      = (state_q == StHalt);
`else
  assign bus.halted      = 1'b0;
`endif

endmodule

// File: doc/fetch_controller.md
FETCH_CONTROLLER -- requirements
Module: fetch_controller

Interface
REQ-001 Parameter: RESET_PC, 32'h0000_0000, PC value loaded by reset.
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst  input  1  reset, asynchronous, active-high.
REQ-004 Port: mem_req  output  1  fetch request to instruction memory.
REQ-005 Port: mem_addr  output  32  byte address of requested word (memory indexes word with addr[9:2]).
REQ-006 Port: mem_rdata  input  32  instruction word from memory; sampled only when mem_ack=1.
REQ-007 Port: mem_ack  input  1  memory response valid; may assert same cycle as mem_req or any later cycle.
REQ-008 Port: instr  output  32  fetched instruction held for decode.
REQ-009 Port: instr_valid  output  1  instr and pc_out valid.
REQ-010 Port: instr_ready  input  1  decode accepts instr when instr_valid=1.
REQ-011 Port: pc_out  output  32  address of instruction presented on instr.
REQ-012 Port: redirect  input  1  branch/jump request, single-cycle pulse or level.
REQ-013 Port: redirect_pc  input  32  target address; bits [1:0] forced to 0.
REQ-014 Port: halted  output  1  controller in HALT state.

Function
REQ-015 States: IDLE, REQ, HOLD, HALT; encoding free, no other reachable states.
REQ-016 IDLE: entered only from reset; unconditional transition to REQ next cycle; mem_req=0.
REQ-017 REQ: mem_req=1, mem_addr=pc; on mem_ack=1 capture mem_rdata into instr, pc into pc_out, go HOLD.
REQ-018 HOLD: instr_valid=1, mem_req=0; instr/pc_out stable until accepted.
REQ-019 HOLD with instr_ready=1: pc <= pc+4 (modulo 2^32), go REQ; min throughput 1 instruction per 2 cycles.
REQ-020 HOLD with instr_ready=0: remain HOLD, all outputs unchanged.
REQ-021 redirect=1 in IDLE, REQ, HOLD or HALT: highest priority; pc <= {redirect_pc[31:2],2'b00}; instr_valid <= 0; go REQ next cycle.
REQ-022 redirect with mem_ack same cycle in REQ: response discarded, instr/pc_out not updated.
REQ-023 redirect with instr_ready same cycle in HOLD: handshake ignored, pc not incremented; decode treats instruction as flushed.
REQ-024 mem_ack while not in REQ: ignored.
REQ-025 mem_addr equals pc in all states; mem_req is 1 only in REQ.
REQ-026 HALT: mem_req=0, instr_valid=0, halted=1; exited only by redirect or reset.
REQ-027 PC wrap: pc=32'hFFFF_FFFC accepted -> next pc 32'h0000_0000, no error flag.

Reset
REQ-028 rst=1 asynchronously forces: state=IDLE, pc=RESET_PC, mem_req=0, instr=0, instr_valid=0, pc_out=RESET_PC, halted=0.
REQ-029 Reset mid-request: outstanding access abandoned; any mem_ack during or in first cycle after reset ignored.
REQ-030 First mem_req after reset release: asserted second rising edge after rst deassertion (IDLE then REQ).

Configuration
REQ-031 Macro FETCH_ZERO_HALT_EN defined: in HOLD, when instr==32'h0000_0000 and instr_ready=1 and redirect=0, go HALT instead of REQ; pc not incremented.
REQ-032 Macro FETCH_ZERO_HALT_EN undefined: zero word treated as normal instruction (NOP); HALT unreachable; halted constant 0.

Verification
REQ-033 Reset, memory acks same cycle, instr_ready=1 constant, words 0x20080005,0x20090003 at 0x0,0x4 -> instr_valid every 2nd cycle, pc_out 0x0 then 0x4, instr matches.
REQ-034 mem_ack delayed 3 cycles, instr_ready low 2 cycles in HOLD -> mem_req high exactly while in REQ, instr/pc_out stable through stall, single pc+4 after accept.
REQ-035 redirect to 0x0000_0043 same cycle as mem_ack at pc 0x8 -> ack data discarded, next mem_addr 0x0000_0040, next pc_out 0x40.
REQ-036 FETCH_ZERO_HALT_EN defined, word at 0xC is 0 -> halted=1 after accept, mem_req stays 0; redirect to 0x0 -> halted=0, mem_req next cycle at addr 0x0. Undefined: fetch continues to 0x10.
REQ-037 rst asserted while in REQ with mem_ack pending -> outputs reset immediately (asynchronous), pc_out=RESET_PC, fetch restarts at RESET_PC.
REQ-038 RESET_PC=32'hFFFF_FFFC, one accept -> next mem_addr 32'h0000_0000.
